// File: rtl/m_mem_arbiter.sv
// Two-port arbiter (instruction fetch / data) in front of one synchronous-read 2048x32 memory.
// Build option: define ARB_RR_EN for round-robin contention instead of DM priority with starvation guard.
module m_mem_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 32
) (
    input  logic             w_clk,
    input  logic             w_rst,
    input  logic             w_if_req,
    input  logic [10:0]      w_if_addr,
    output logic             w_if_gnt,
    output logic             r_if_vld,
    output logic [31:0]      w_if_data,
    input  logic             w_dm_req,
    input  logic             w_dm_we,
    input  logic [10:0]      w_dm_addr,
    input  logic [31:0]      w_dm_wdata,
    output logic             w_dm_gnt,
    output logic             r_dm_vld,
    output logic [31:0]      w_dm_rdata,
    output logic [10:0]      w_mem_addr,
    output logic             w_mem_we,
    output logic [31:0]      w_mem_din,
    input  logic [31:0]      w_mem_dout,
    output logic [CNT_W-1:0] r_if_stall_cnt
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_t;

    owner_t r_owner;
    owner_t w_owner_nxt;
    logic   w_if_stall;

`ifdef ARB_RR_EN
    localparam logic LAST_IF = 1'b0;
    localparam logic LAST_DM = 1'b1;
    logic r_last;
`else
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    logic [3:0] r_starve;
`endif

    // Grant decision: single requester wins outright, contention resolved by policy.
    always_comb begin
        w_if_gnt = 1'b0;
        w_dm_gnt = 1'b0;
        if (w_rst) begin
            w_if_gnt = 1'b0;
            w_dm_gnt = 1'b0;
        end else if (w_if_req && w_dm_req) begin
`ifdef ARB_RR_EN
            if (r_last == LAST_DM) begin
                w_if_gnt = 1'b1;
            end else begin
                w_dm_gnt = 1'b1;
            end
`else
            if (r_starve == STARVE_LIM) begin
                w_if_gnt = 1'b1;
            end else begin
                w_dm_gnt = 1'b1;
            end
`endif
        end else begin
            w_if_gnt = w_if_req;
            w_dm_gnt = w_dm_req;
        end
    end

    // Memory mux and next read owner.
    always_comb begin
        w_owner_nxt = OWN_NONE;
        if (w_if_gnt) begin
            w_mem_addr  = w_if_addr;
            w_owner_nxt = OWN_IF;
        end else if (w_dm_gnt) begin
            w_mem_addr  = w_dm_addr;
            w_owner_nxt = w_dm_we ? OWN_NONE : OWN_DM;
        end else begin
            w_mem_addr  = 11'd0;
            w_owner_nxt = OWN_NONE;
        end
    end

    assign w_mem_we   = w_dm_gnt & w_dm_we;
    assign w_mem_din  = w_dm_wdata;
    assign w_if_data  = w_mem_dout;
    assign w_dm_rdata = w_mem_dout;
    assign w_if_stall = w_if_req & ~w_if_gnt;

    // Reset in the return cycle suppresses the pending valid.
    assign r_if_vld = ~w_rst & (r_owner == OWN_IF);
    assign r_dm_vld = ~w_rst & (r_owner == OWN_DM);

    // Read-return owner tracking and saturating IF stall counter.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_owner        <= OWN_NONE;
            r_if_stall_cnt <= '0;
        end else begin
            r_owner <= w_owner_nxt;
            if (w_if_stall && (r_if_stall_cnt != {CNT_W{1'b1}})) begin
                r_if_stall_cnt <= r_if_stall_cnt + CNT_W'(1);
            end
        end
    end

`ifdef ARB_RR_EN
    // Remember the most recently granted port for round-robin.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_last <= LAST_IF;
        end else if (w_if_gnt) begin
            r_last <= LAST_IF;
        end else if (w_dm_gnt) begin
            r_last <= LAST_DM;
        end
    end
`else
    // Consecutive denied-IF cycles, saturating until IF is served.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_starve <= 4'd0;
        end else if (!w_if_req || w_if_gnt) begin
            r_starve <= 4'd0;
        end else if (r_starve != STARVE_LIM) begin
            r_starve <= r_starve + 4'd1;
        end
    end
`endif

endmodule

// File: tb/tb_m_mem_arbiter.sv
// Randomized bench for m_mem_arbiter with a behavioural arbitration/memory reference model.
module tb_m_mem_arbiter;

    localparam int STARVE_MAX = 4;

    logic        w_clk;
    logic        w_rst;
    logic        w_if_req;
    logic [10:0] w_if_addr;
    logic        w_if_gnt;
    logic        r_if_vld;
    logic [31:0] w_if_data;
    logic        w_dm_req;
    logic        w_dm_we;
    logic [10:0] w_dm_addr;
    logic [31:0] w_dm_wdata;
    logic        w_dm_gnt;
    logic        r_dm_vld;
    logic [31:0] w_dm_rdata;
    logic [10:0] w_mem_addr;
    logic        w_mem_we;
    logic [31:0] w_mem_din;
    logic [31:0] w_mem_dout;
    logic [31:0] r_if_stall_cnt;

    // Second instance with a 3-bit stall counter; shares all inputs.
    logic        s_if_gnt, s_if_vld, s_dm_gnt, s_dm_vld, s_mem_we;
    logic [31:0] s_if_data, s_dm_rdata, s_mem_din;
    logic [10:0] s_mem_addr;
    logic [2:0]  s_stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem     [2048];
    logic [31:0] ref_mem [2048];

    // Reference model state
    int          m_streak;
    bit          m_last_dm;
    logic [31:0] m_stall;
    int          m_stall3;
    bit          m_if_vld, m_dm_vld;
    logic [31:0] m_data;

    m_mem_arbiter #(.STARVE_MAX(STARVE_MAX), .CNT_W(32)) dut (
        .w_clk(w_clk), .w_rst(w_rst),
        .w_if_req(w_if_req), .w_if_addr(w_if_addr), .w_if_gnt(w_if_gnt),
        .r_if_vld(r_if_vld), .w_if_data(w_if_data),
        .w_dm_req(w_dm_req), .w_dm_we(w_dm_we), .w_dm_addr(w_dm_addr),
        .w_dm_wdata(w_dm_wdata), .w_dm_gnt(w_dm_gnt), .r_dm_vld(r_dm_vld),
        .w_dm_rdata(w_dm_rdata), .w_mem_addr(w_mem_addr), .w_mem_we(w_mem_we),
        .w_mem_din(w_mem_din), .w_mem_dout(w_mem_dout), .r_if_stall_cnt(r_if_stall_cnt)
    );

    m_mem_arbiter #(.STARVE_MAX(STARVE_MAX), .CNT_W(3)) dut3 (
        .w_clk(w_clk), .w_rst(w_rst),
        .w_if_req(w_if_req), .w_if_addr(w_if_addr), .w_if_gnt(s_if_gnt),
        .r_if_vld(s_if_vld), .w_if_data(s_if_data),
        .w_dm_req(w_dm_req), .w_dm_we(w_dm_we), .w_dm_addr(w_dm_addr),
        .w_dm_wdata(w_dm_wdata), .w_dm_gnt(s_dm_gnt), .r_dm_vld(s_dm_vld),
        .w_dm_rdata(s_dm_rdata), .w_mem_addr(s_mem_addr), .w_mem_we(s_mem_we),
        .w_mem_din(s_mem_din), .w_mem_dout(w_mem_dout), .r_if_stall_cnt(s_stall_cnt)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    // Behavioural single-port synchronous-read memory
    always @(posedge w_clk) begin
        if (w_mem_we) mem[w_mem_addr] <= w_mem_din;
        w_mem_dout <= mem[w_mem_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, check against the model, advance the model.
    task automatic step(input logic rst, input logic ifr, input logic [10:0] ia,
                        input logic dmr, input logic we, input logic [10:0] da,
                        input logic [31:0] wd, output logic gi, output logic gd);
        logic [10:0] ea;
        @(negedge w_clk);
        w_rst = rst; w_if_req = ifr; w_if_addr = ia;
        w_dm_req = dmr; w_dm_we = we; w_dm_addr = da; w_dm_wdata = wd;
        gi = 1'b0; gd = 1'b0;
        if (!rst) begin
            if (ifr && dmr) begin
`ifdef ARB_RR_EN
                gi = m_last_dm;
`else
                gi = (m_streak >= STARVE_MAX);
`endif
                gd = !gi;
            end else begin
                gi = ifr; gd = dmr;
            end
        end
        ea = gi ? ia : (gd ? da : 11'd0);
        #1;
        check_eq("if_gnt",   {31'd0, w_if_gnt}, {31'd0, gi});
        check_eq("dm_gnt",   {31'd0, w_dm_gnt}, {31'd0, gd});
        check_eq("mem_addr", {21'd0, w_mem_addr}, {21'd0, ea});
        check_eq("mem_we",   {31'd0, w_mem_we}, {31'd0, gd & we});
        check_eq("mem_din",  w_mem_din, wd);
        check_eq("if_vld",   {31'd0, r_if_vld}, {31'd0, m_if_vld & !rst});
        check_eq("dm_vld",   {31'd0, r_dm_vld}, {31'd0, m_dm_vld & !rst});
        if (m_if_vld && !rst) check_eq("if_data", w_if_data, m_data);
        if (m_dm_vld && !rst) check_eq("dm_rdata", w_dm_rdata, m_data);
        check_eq("stall_cnt",  r_if_stall_cnt, m_stall);
        check_eq("stall_cnt3", {29'd0, s_stall_cnt}, m_stall3);
        if (rst) begin
            m_if_vld = 0; m_dm_vld = 0; m_streak = 0; m_last_dm = 0;
            m_stall = 32'd0; m_stall3 = 0;
        end else begin
            m_if_vld = gi;
            m_dm_vld = gd && !we;
            m_data   = gi ? ref_mem[ia] : ref_mem[da];
            if (gd && we) ref_mem[da] = wd;
            if (ifr && !gi) begin
                m_streak = (m_streak < STARVE_MAX) ? m_streak + 1 : STARVE_MAX;
                if (m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
                if (m_stall3 < 7) m_stall3++;
            end else begin
                m_streak = 0;
            end
            if (gi) m_last_dm = 0;
            else if (gd) m_last_dm = 1;
        end
    endtask

    initial begin
        logic gi, gd;
        logic p_if, p_dm, p_we;
        logic [10:0] p_ia, p_da;
        logic [31:0] p_wd;
        w_rst = 1'b1; w_if_req = 1'b0; w_if_addr = 11'd0; w_dm_req = 1'b0;
        w_dm_we = 1'b0; w_dm_addr = 11'd0; w_dm_wdata = 32'd0;
        for (int i = 0; i < 2048; i++) begin
            mem[i] = (i * 32'h9E37_79B1) ^ 32'h5A5A_0000;
        end
        mem[5] = 32'h8C01_0004;
        for (int i = 0; i < 2048; i++) ref_mem[i] = mem[i];
        m_streak = 0; m_last_dm = 0; m_stall = 32'd0; m_stall3 = 0;
        m_if_vld = 0; m_dm_vld = 0; m_data = 32'd0;

        step(1'b1, 1'b0, 11'd0, 1'b0, 1'b0, 11'd0, 32'd0, gi, gd);
        step(1'b1, 1'b1, 11'd3, 1'b1, 1'b1, 11'd3, 32'd1, gi, gd);
        check_eq("rst_mem_we", {31'd0, w_mem_we}, 32'd0);

        // IF-only fetch of word 5
        step(1'b0, 1'b1, 11'h005, 1'b0, 1'b0, 11'd0, 32'd0, gi, gd);
        check_eq("if5_addr", {21'd0, w_mem_addr}, 32'h5);
        step(1'b0, 1'b0, 11'd0, 1'b0, 1'b0, 11'd0, 32'd0, gi, gd);
        check_eq("if5_data", w_if_data, 32'h8C01_0004);
        check_eq("if5_dmvld", {31'd0, r_dm_vld}, 32'd0);

        // Store then load to 0x010
        step(1'b0, 1'b0, 11'd0, 1'b1, 1'b1, 11'h010, 32'hDEAD_BEEF, gi, gd);
        check_eq("st_we", {31'd0, w_mem_we}, 32'd1);
        step(1'b0, 1'b0, 11'd0, 1'b1, 1'b0, 11'h010, 32'd0, gi, gd);
        check_eq("ld_we", {31'd0, w_mem_we}, 32'd0);
        check_eq("st_novld", {31'd0, r_dm_vld}, 32'd0);
        step(1'b0, 1'b0, 11'd0, 1'b0, 1'b0, 11'd0, 32'd0, gi, gd);
        check_eq("ld_vld", {31'd0, r_dm_vld}, 32'd1);
        check_eq("ld_data", w_dm_rdata, 32'hDEAD_BEEF);

        // Continuous contention from a fresh reset
        step(1'b1, 1'b0, 11'd0, 1'b0, 1'b0, 11'd0, 32'd0, gi, gd);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 11'(i), 1'b1, 1'b0, 11'(i + 100), 32'd0, gi, gd);
`ifdef ARB_RR_EN
            check_eq("cont_pat", {31'd0, w_if_gnt}, {31'd0, 1'(i % 2)});
`else
            check_eq("cont_pat", {31'd0, w_if_gnt}, {31'd0, 1'(i == 4 || i == 9)});
`endif
        end
        step(1'b0, 1'b0, 11'd0, 1'b0, 1'b0, 11'd0, 32'd0, gi, gd);
`ifdef ARB_RR_EN
        check_eq("cont_stall", r_if_stall_cnt, 32'd5);
`else
        check_eq("cont_stall", r_if_stall_cnt, 32'd8);
        check_eq("sat3", {29'd0, s_stall_cnt}, 32'd7);
`endif

        // Reset in the cycle after an IF grant
        step(1'b0, 1'b1, 11'd7, 1'b0, 1'b0, 11'd0, 32'd0, gi, gd);
        step(1'b1, 1'b0, 11'd0, 1'b0, 1'b0, 11'd0, 32'd0, gi, gd);
        check_eq("rmid_vld1", {31'd0, r_if_vld}, 32'd0);
        step(1'b0, 1'b0, 11'd0, 1'b0, 1'b0, 11'd0, 32'd0, gi, gd);
        check_eq("rmid_vld2", {31'd0, r_if_vld}, 32'd0);
        check_eq("rmid_cnt", r_if_stall_cnt, 32'd0);

        // Random traffic; denied requesters hold their request
        p_if = 0; p_dm = 0; p_we = 0; p_ia = 0; p_da = 0; p_wd = 0;
        for (int n = 0; n < 400; n++) begin
            logic rst;
            rst = ($urandom_range(0, 99) == 0);
            if (!p_if) begin
                p_if = ($urandom_range(0, 3) != 0);
                p_ia = 11'($urandom_range(0, 31));
            end
            if (!p_dm) begin
                p_dm = ($urandom_range(0, 2) != 0);
                p_we = $urandom_range(0, 1);
                p_da = 11'($urandom_range(0, 31));
                p_wd = $urandom;
            end
            step(rst, p_if, p_ia, p_dm, p_we, p_da, p_wd, gi, gd);
            if (gi) p_if = 0;
            if (gd) p_dm = 0;
        end
        step(1'b0, 1'b0, 11'd0, 1'b0, 1'b0, 11'd0, 32'd0, gi, gd);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
